game_input_controller: RTL

Parametrised successor to the two-input combinational game controller. Synchronises and debounces NUM_BUTTONS raw button inputs and produces stable levels, one-cycle press/release pulses, and a configurable multi-button combo detect (generalising the fixed A&B). It also buffers press/release events in a small valid/ready FIFO for the game engine FSM. It sits between the board button pins and the GameEngine core.

---
 rtl/game_input_pkg.sv | 18 +
 rtl/game_input_controller_debouncer.sv | 56 +++++
 rtl/game_input_controller.sv | 105 ++++++++++
 3 files changed

// File: rtl/game_input_pkg.sv
// Shared types, defaults and sizing helper for the game input controller.
package game_input_pkg;

   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_NUM_BUTTONS     = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_FIFO_DEPTH      = 4;
   localparam int DEF_IDX_W           = clog2_min1(DEF_NUM_BUTTONS);

   typedef struct packed {
      logic                 is_press;
      logic [DEF_IDX_W-1:0] idx;
   } evt_t;

endpackage

// File: rtl/game_input_controller_debouncer.sv
// One button channel: 2-FF synchroniser plus saturating debounce counter that
// requests a commit and only changes its level when the top grants it.
module input_debouncer
   import game_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw_i,
   input  logic commit_gnt_i,
   output logic commit_req_o,
   output logic btn_state_o
);
   localparam int               CNT_W   = clog2_min1(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             differ;

   assign differ       = (sync2_q != state_q);
   assign commit_req_o = differ && (cnt_q == CNT_MAX);
   assign btn_state_o  = state_q;

   // A losing requester holds at CNT_MAX; any reversion clears the count.
   always_comb begin
      cnt_d   = '0;
      state_d = state_q;
      if (differ) begin
         if (commit_gnt_i) begin
            state_d = ~state_q;
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/game_input_controller.sv
// Debounced multi-button front end: per-channel debouncers, lowest-index commit
// arbitration, press/release pulses, combo detect and a press/release event FIFO.
module game_input_controller
   import game_input_pkg::*;
#(
   parameter int                     NUM_BUTTONS     = DEF_NUM_BUTTONS,
   parameter int                     DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter logic [NUM_BUTTONS-1:0] COMBO_MASK      = NUM_BUTTONS'(3),
   parameter int                     FIFO_DEPTH      = DEF_FIFO_DEPTH,
   localparam int                    IDX_W           = clog2_min1(NUM_BUTTONS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BUTTONS-1:0] btn_raw,
   output logic [NUM_BUTTONS-1:0] btn_state,
   output logic [NUM_BUTTONS-1:0] btn_press,
   output logic [NUM_BUTTONS-1:0] btn_release,
   output logic                   combo_active,
   output logic                   combo_press,
   output logic                   evt_valid,
   input  logic                   evt_ready,
   output logic [IDX_W:0]         evt_data,
   output logic                   overflow
);
   localparam int PTR_W = clog2_min1(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_BUTTONS-1:0] req, gnt;
   logic [NUM_BUTTONS-1:0] press_q, release_q;
   logic                   combo_prev_q;
   logic                   push, pop, full, push_acc;
   logic [IDX_W:0]         push_data;
   logic [IDX_W:0]         mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_q, rd_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ovf_q;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
      input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk          (clk),
         .reset        (reset),
         .btn_raw_i    (btn_raw[i]),
         .commit_gnt_i (gnt[i]),
         .commit_req_o (req[i]),
         .btn_state_o  (btn_state[i])
      );
   end

   // Isolate the lowest set request bit.
   assign gnt  = req & (~req + 1'b1);
   assign push = |gnt;

   always_comb begin
      push_data = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         if (gnt[i]) push_data = {~btn_state[i], IDX_W'(i)};
      end
   end

   assign combo_active = ((btn_state & COMBO_MASK) == COMBO_MASK);
   assign combo_press  = combo_active && !combo_prev_q;
   assign btn_press    = press_q;
   assign btn_release  = release_q;

   assign evt_valid = (cnt_q != '0);
   assign evt_data  = mem_q[rd_q];
   assign overflow  = ovf_q;
   assign full      = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign pop       = evt_valid && evt_ready;
   assign push_acc  = push && (!full || pop);

   always_comb begin
      cnt_d = cnt_q;
      case ({push_acc, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         press_q      <= '0;
         release_q    <= '0;
         combo_prev_q <= 1'b0;
         wr_q         <= '0;
         rd_q         <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
      end else begin
         press_q      <= gnt & ~btn_state;
         release_q    <= gnt & btn_state;
         combo_prev_q <= combo_active;
         cnt_q        <= cnt_d;
         if (push_acc) begin
            mem_q[wr_q] <= push_data;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         if (push && !push_acc) ovf_q <= 1'b1;
      end
   end

endmodule
